// File: rtl/fifo_ctrl_param_pkg.sv
// Shared defaults for the per-lane FIFO controllers.
// Each lane instance takes its widths, depth and almost-full/almost-empty
// thresholds from this package unless it overrides them.
package fifo_ctrl_param_pkg;

  localparam int FIFO_MEM_WIDTH  = 10;
  localparam int FIFO_MEM_DEPTH  = 8;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_AF_TH      = 6;
  localparam int FIFO_AE_TH      = 2;

endpackage

// File: rtl/fifo_ctrl_param_if.sv
// Producer/consumer handshake bundle for fifo_ctrl_param.
//   master : drives fifo_wr, Fifo_Data_in, fifo_rd; observes data and status
//   slave  : the FIFO side; drives Fifo_Data_out, fifo_valid, the flags and
//            fifo_count
interface fifo_ctrl_param_if
  import fifo_ctrl_param_pkg::*;
#(
  parameter int MEM_WIDTH  = FIFO_MEM_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  fifo_wr;
  logic [MEM_WIDTH-1:0]  Fifo_Data_in;
  logic                  fifo_rd;
  logic [MEM_WIDTH-1:0]  Fifo_Data_out;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic [ADDR_WIDTH:0]   fifo_count;

  modport master (
    output fifo_wr, Fifo_Data_in, fifo_rd,
    input  Fifo_Data_out, fifo_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fifo_error, fifo_count
  );

  modport slave (
    input  fifo_wr, Fifo_Data_in, fifo_rd,
    output Fifo_Data_out, fifo_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fifo_error, fifo_count
  );

endinterface

// File: rtl/fifo_ctrl_param_mem_dp.sv
// Dual-port storage array for fifo_ctrl_param.
//   clk, reset        : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : synchronous write port
//   rd_en/addr        : synchronous read port with enable
//   rd_data           : registered read data, holds when rd_en is low
// The array itself is never cleared. A read and a write to the same address
// in one cycle return the old word, which is what lets a full FIFO pop the
// oldest entry while refilling that slot.
module fifo_mem_dp
  import fifo_ctrl_param_pkg::*;
#(
  parameter int WIDTH = FIFO_MEM_WIDTH,
  parameter int DEPTH = FIFO_MEM_DEPTH,
  parameter int AW    = FIFO_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_ctrl_param.sv
// Parametrised synchronous FIFO controller with internal pointers.
//   clk    : single clock
//   reset  : synchronous, active-high; clears pointers, count, output, valid, error
//   bus    : slave side of fifo_ctrl_param_if (write/read requests, read data,
//            fifo_valid, full/empty/almost flags, sticky fifo_error, fifo_count)
// Flags decode the registered count, so they follow an operation by one cycle.
module fifo_ctrl_param
  import fifo_ctrl_param_pkg::*;
#(
  parameter int MEM_WIDTH  = FIFO_MEM_WIDTH,
  parameter int MEM_DEPTH  = FIFO_MEM_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_TH      = FIFO_AF_TH,
  parameter int AE_TH      = FIFO_AE_TH
) (
  input  logic             clk,
  input  logic             reset,
  fifo_ctrl_param_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  overflow, underflow;
  logic                  valid, error;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A full FIFO still takes a write when a read frees a slot the same cycle;
  // an empty FIFO never bypasses a write straight to the read side.
  assign rd_acc    = bus.fifo_rd & ~empty;
  assign wr_acc    = bus.fifo_wr & (~full | rd_acc);
  assign overflow  = bus.fifo_wr & full & ~rd_acc;
  assign underflow = bus.fifo_rd & empty;

  fifo_mem_dp #(
    .WIDTH (MEM_WIDTH),
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc & ~reset),
    .wr_addr (wr_ptr),
    .wr_data (bus.Fifo_Data_in),
    .rd_en   (rd_acc & ~reset),
    .rd_addr (rd_ptr),
    .rd_data (bus.Fifo_Data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      error  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      valid <= rd_acc;
      if (overflow | underflow) error <= 1'b1;
    end
  end

  assign bus.fifo_valid   = valid;
  assign bus.fifo_error   = error;
  assign bus.fifo_count   = count;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count >= AF_C);
  assign bus.almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Bench for fifo_ctrl_param: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fifo_ctrl_param;

  localparam int W     = 10;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic reset;

  fifo_ctrl_param_if #(.MEM_WIDTH(W), .ADDR_WIDTH(3)) bus ();

  fifo_ctrl_param #(
    .MEM_WIDTH(W), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(3), .AF_TH(AF), .AE_TH(AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  string       phase    = "init";

  int          mq[$];
  logic [W-1:0] m_dout  = '0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count",        32'(bus.fifo_count),   32'(n));
    chk("full",         32'(bus.fifo_full),    32'(n == DEPTH));
    chk("empty",        32'(bus.fifo_empty),   32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("error",        32'(bus.fifo_error),   32'(m_err));
    chk("valid",        32'(bus.fifo_valid),   32'(m_valid));
    chk("data_out",     32'(bus.Fifo_Data_out), 32'(m_dout));
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, compare.
  task automatic step(input bit rst, input bit wr, input logic [W-1:0] din, input bit rd);
    bit full, empty, rd_ok, wr_ok;
    reset            = rst;
    bus.fifo_wr      = wr;
    bus.Fifo_Data_in = din;
    bus.fifo_rd      = rd;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      rd_ok = rd && !empty;
      wr_ok = wr && (!full || rd_ok);
      if (wr && full && !rd_ok) m_err = 1'b1;
      if (rd && empty)          m_err = 1'b1;
      m_valid = rd_ok;
      if (rd_ok) m_dout = W'(mq.pop_front());
      if (wr_ok) mq.push_back(int'(din));
    end
    #1;
    check_all();
  endtask

  initial begin
    int bias_wr, bias_rd;
    bit r, w, d;

    phase = "reset";
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    phase = "fill";
    for (int i = 1; i <= 8; i++) step(0, 1, W'(i), 0);
    phase = "drain";
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    phase = "passthru";
    for (int i = 0; i < 8; i++) step(0, 1, W'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 5; i++) step(0, 1, W'(10'h100 + i), 1);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);

    phase = "overflow";
    for (int i = 0; i < 8; i++) step(0, 1, W'($urandom_range(0, 255)), 0);
    step(0, 1, 10'h3FF, 0);
    step(0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);
    phase = "underflow";
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    phase = "empty_wr_rd";
    step(1, 0, '0, 0);
    step(0, 1, 10'h2AA, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    phase = "reset_mid_read";
    for (int i = 0; i < 5; i++) step(0, 1, W'(10'h010 + i), 0);
    step(1, 0, '0, 1);
    step(0, 1, 10'h055, 0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    phase = "random";
    for (int blk = 0; blk < 8; blk++) begin
      bias_wr = (blk % 2 == 0) ? 80 : 30;
      bias_rd = (blk % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 80; i++) begin
        r = ($urandom_range(0, 63) == 0);
        w = ($urandom_range(0, 99) < bias_wr);
        d = ($urandom_range(0, 99) < bias_rd);
        step(r, w, W'($urandom_range(0, 1023)), d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
